cnn_axi_write_slave: RTL and testbench

AXI4 write-channel slave for the CNN accelerator (SLAVE6 window, 0xD000_0000–0xDFFF_FFFF), sitting directly upstream of the accelerator controller. It accepts AW/W bursts from the bus, splits every accepted data beat into a single-cycle `ctrl_awaddr/ctrl_awvalid/ctrl_wdata/ctrl_wvalid` pulse, and returns the B response. The controller decodes register and local-memory writes from those pulses, so one pulse must equal exactly one stored word.

---
 rtl/cnn_axi_write_slave.sv | 144 ++++++++++++++
 tb/tb_cnn_axi_write_slave.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_axi_write_slave.sv
// AXI4 write-channel slave for the CNN accelerator window.
// Each accepted W beat becomes one registered ctrl_* pulse; one transaction is outstanding at a time.
module cnn_axi_write_slave #(
    parameter int ID_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_WIDTH-1:0] AWID,
    input  logic [31:0]         AWADDR,
    input  logic [7:0]          AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [31:0]         WDATA,
    input  logic [3:0]          WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [ID_WIDTH-1:0] BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    output logic [31:0]         ctrl_awaddr,
    output logic                ctrl_awvalid,
    output logic [31:0]         ctrl_wdata,
    output logic                ctrl_wvalid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic                r_live;
    logic [ID_WIDTH-1:0] r_awid;
    logic [31:0]         r_awaddr;
    logic [7:0]          r_awlen;
    logic [1:0]          r_awburst;
    logic [8:0]          r_beatCnt;
    logic                r_err;

    logic [31:0]         r_ctrlAddr;
    logic [31:0]         r_ctrlData;
    logic                r_ctrlValid;

    logic                w_awHs;
    logic                w_wHs;
    logic                w_lastBeat;
    logic                w_awErr;
    logic                w_beatErr;
    logic [31:0]         w_beatAddr;

    assign w_awHs     = AWVALID && AWREADY;
    assign w_wHs      = WVALID && WREADY;
    assign w_lastBeat = (r_beatCnt == {1'b0, r_awlen});
    assign w_awErr    = (AWSIZE != 3'b010) || AWBURST[1];
    assign w_beatErr  = (WSTRB != 4'hF) || (WLAST != w_lastBeat);
    assign w_beatAddr = (r_awburst == 2'b00) ? r_awaddr
                                             : r_awaddr + {21'd0, r_beatCnt, 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_awHs)                w_nextState = DATA;
            DATA:    if (w_wHs && w_lastBeat)   w_nextState = RESP;
            RESP:    if (BREADY)                w_nextState = IDLE;
            default:                            w_nextState = IDLE;
        endcase
    end

    // r_live keeps AWREADY low while reset is held and for the edge that releases it
    always_comb begin
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        case (r_state)
            IDLE:    AWREADY = r_live;
            DATA:    WREADY  = 1'b1;
            RESP:    BVALID  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_live    <= 1'b0;
            r_awid    <= '0;
            r_awaddr  <= '0;
            r_awlen   <= '0;
            r_awburst <= '0;
            r_beatCnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_awHs) begin
                r_awid    <= AWID;
                r_awaddr  <= AWADDR;
                r_awlen   <= AWLEN;
                r_awburst <= AWBURST;
                r_beatCnt <= '0;
                r_err     <= w_awErr;
            end else if (w_wHs) begin
                r_beatCnt <= r_beatCnt + 9'd1;
                r_err     <= r_err | w_beatErr;
            end
        end
    end

    // Erroneous beats are forwarded unchanged; the error only shows up in BRESP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctrlValid <= 1'b0;
            r_ctrlAddr  <= '0;
            r_ctrlData  <= '0;
        end else begin
            r_ctrlValid <= w_wHs;
            if (w_wHs) begin
                r_ctrlAddr <= w_beatAddr;
                r_ctrlData <= WDATA;
            end
        end
    end

    assign BID          = r_awid;
    assign BRESP        = r_err ? 2'b10 : 2'b00;
    assign ctrl_awaddr  = r_ctrlAddr;
    assign ctrl_wdata   = r_ctrlData;
    assign ctrl_awvalid = r_ctrlValid;
    assign ctrl_wvalid  = r_ctrlValid;

endmodule

// File: tb/tb_cnn_axi_write_slave.sv
// Directed self-checking bench for cnn_axi_write_slave.
// A negedge monitor records every ctrl pulse with its cycle number for later checking.
module tb_cnn_axi_write_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ctrl_awaddr;
    logic        ctrl_awvalid;
    logic [31:0] ctrl_wdata;
    logic        ctrl_wvalid;

    int          assertCount = 0;
    int          failCount   = 0;
    int          cycle       = 0;
    int          awCycle     = 0;
    int          wCycle      = 0;
    int          pairErr     = 0;
    logic [31:0] obsAddr[$];
    logic [31:0] obsData[$];
    int          obsCycle[$];

    cnn_axi_write_slave #(.ID_WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .AWID         (AWID),
        .AWADDR       (AWADDR),
        .AWLEN        (AWLEN),
        .AWSIZE       (AWSIZE),
        .AWBURST      (AWBURST),
        .AWVALID      (AWVALID),
        .AWREADY      (AWREADY),
        .WDATA        (WDATA),
        .WSTRB        (WSTRB),
        .WLAST        (WLAST),
        .WVALID       (WVALID),
        .WREADY       (WREADY),
        .BID          (BID),
        .BRESP        (BRESP),
        .BVALID       (BVALID),
        .BREADY       (BREADY),
        .ctrl_awaddr  (ctrl_awaddr),
        .ctrl_awvalid (ctrl_awvalid),
        .ctrl_wdata   (ctrl_wdata),
        .ctrl_wvalid  (ctrl_wvalid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (ctrl_awvalid !== ctrl_wvalid) pairErr++;
        if (ctrl_awvalid === 1'b1) begin
            obsAddr.push_back(ctrl_awaddr);
            obsData.push_back(ctrl_wdata);
            obsCycle.push_back(cycle);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic clearPulses();
        obsAddr.delete();
        obsData.delete();
        obsCycle.delete();
    endtask

    task automatic awSend(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        @(negedge clk);
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        while (!AWREADY && n < 1000) begin @(negedge clk); n++; end
        if (!AWREADY) begin
            checkOutput("awready_timeout", 0, 1);
            AWVALID = 1'b0;
            return;
        end
        @(posedge clk);
        awCycle = cycle;
        #1 AWVALID = 1'b0;
    endtask

    task automatic wSend(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        @(negedge clk);
        WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
        while (!WREADY && n < 1000) begin @(negedge clk); n++; end
        if (!WREADY) begin
            checkOutput("wready_timeout", 0, 1);
            WVALID = 1'b0;
            return;
        end
        @(posedge clk);
        wCycle = cycle;
        #1 WVALID = 1'b0; WLAST = 1'b0;
    endtask

    // First check lands in the cycle right after the final W handshake
    task automatic bTake(input logic [3:0] id, input logic [1:0] resp, input int holdLow);
        @(negedge clk);
        checkOutput("bvalid_after_last_w", BVALID, 1);
        for (int i = 0; i < holdLow; i++) begin
            checkOutput("bvalid_hold", BVALID, 1);
            checkOutput("bid_hold", BID, id);
            checkOutput("bresp_hold", BRESP, resp);
            checkOutput("awready_hold", AWREADY, 0);
            @(negedge clk);
        end
        checkOutput("bid", BID, id);
        checkOutput("bresp", BRESP, resp);
        BREADY = 1'b1;
        @(posedge clk);
        #1 BREADY = 1'b0;
        @(negedge clk);
        checkOutput("awready_after_b", AWREADY, 1);
        checkOutput("bvalid_after_b", BVALID, 0);
    endtask

    task automatic sendBurst(input int n, input logic [31:0] dataBase, input int badStrbBeat,
                             input int lastBeat);
        for (int i = 0; i < n; i++)
            wSend(dataBase + i, (i == badStrbBeat) ? 4'h3 : 4'hF, (i == lastBeat) || (i == n - 1 && lastBeat >= 0));
    endtask

    task automatic checkBurst(input string tag, input int n, input logic [31:0] start,
                              input logic fixed, input logic [31:0] dataBase);
        int bad = 0;
        checkOutput({tag, "_count"}, obsAddr.size(), n);
        if (obsAddr.size() == n) begin
            for (int i = 0; i < n; i++) begin
                if (obsAddr[i] !== (fixed ? start : start + 32'(4 * i))) bad++;
                if (obsData[i] !== dataBase + 32'(i)) bad++;
            end
        end
        checkOutput({tag, "_bad_beats"}, bad, 0);
    endtask

    task automatic applyStimulus();
        int firstW;
        int gaps;

        // single write
        clearPulses();
        awSend(4'd5, 32'hD111_0000, 8'd0, 3'b010, 2'b01);
        wSend(32'h2, 4'hF, 1'b1);
        bTake(4'd5, 2'b00, 0);
        checkBurst("single", 1, 32'hD111_0000, 1'b0, 32'h2);
        if (obsCycle.size() == 1) checkOutput("single_pulse_cycle", obsCycle[0], wCycle + 1);

        // 216-beat INCR burst, continuous
        clearPulses();
        awSend(4'd1, 32'hD333_0000, 8'd215, 3'b010, 2'b01);
        wSend(32'h0, 4'hF, 1'b0);
        firstW = wCycle;
        for (int i = 1; i < 216; i++) wSend(32'(i), 4'hF, i == 215);
        bTake(4'd1, 2'b00, 0);
        checkBurst("incr216", 216, 32'hD333_0000, 1'b0, 32'h0);
        gaps = 0;
        for (int i = 1; i < obsCycle.size(); i++) if (obsCycle[i] != obsCycle[i-1] + 1) gaps++;
        checkOutput("incr216_gaps", gaps, 0);
        if (obsCycle.size() > 0) checkOutput("incr216_first_cycle", obsCycle[0], firstW + 1);
        if (obsAddr.size() == 216) checkOutput("incr216_last_addr", obsAddr[215], 32'hD333_035C);

        // FIXED burst with a 3-cycle WVALID gap and BREADY held off
        clearPulses();
        awSend(4'd9, 32'hD444_0000, 8'd7, 3'b010, 2'b00);
        for (int i = 0; i < 8; i++) begin
            wSend(32'h100 + 32'(i), 4'hF, i == 7);
            if (i == 3) repeat (3) @(negedge clk);
        end
        bTake(4'd9, 2'b00, 5);
        checkBurst("fixed8", 8, 32'hD444_0000, 1'b1, 32'h100);
        if (obsCycle.size() == 8) begin
            checkOutput("fixed8_gap", obsCycle[4] - obsCycle[3], 4);
            checkOutput("fixed8_after_gap", obsCycle[5] - obsCycle[4], 1);
        end

        // WLAST on beat 2 of a 4-beat burst
        clearPulses();
        awSend(4'd2, 32'hD000_1000, 8'd3, 3'b010, 2'b01);
        for (int i = 0; i < 4; i++) wSend(32'h200 + 32'(i), 4'hF, (i == 1) || (i == 3));
        bTake(4'd2, 2'b10, 0);
        checkBurst("early_wlast", 4, 32'hD000_1000, 1'b0, 32'h200);

        // illegal AWSIZE
        clearPulses();
        awSend(4'd3, 32'hD000_2000, 8'd1, 3'b001, 2'b01);
        sendBurst(2, 32'h300, -1, 1);
        bTake(4'd3, 2'b10, 0);
        checkBurst("bad_size", 2, 32'hD000_2000, 1'b0, 32'h300);

        // partial strobe
        clearPulses();
        awSend(4'd4, 32'hD000_3000, 8'd2, 3'b010, 2'b01);
        sendBurst(3, 32'h400, 1, 2);
        bTake(4'd4, 2'b10, 0);
        checkBurst("bad_strb", 3, 32'hD000_3000, 1'b0, 32'h400);

        // clean burst clears the sticky error
        clearPulses();
        awSend(4'd6, 32'hD000_4000, 8'd2, 3'b010, 2'b01);
        sendBurst(3, 32'h500, -1, 2);
        bTake(4'd6, 2'b00, 0);
        checkBurst("clean", 3, 32'hD000_4000, 1'b0, 32'h500);

        // WRAP burst: addresses advance, response is SLVERR
        clearPulses();
        awSend(4'd8, 32'hD000_5000, 8'd2, 3'b010, 2'b10);
        sendBurst(3, 32'h600, -1, 2);
        bTake(4'd8, 2'b10, 0);
        checkBurst("wrap", 3, 32'hD000_5000, 1'b0, 32'h600);

        // WLAST missing on the final beat
        clearPulses();
        awSend(4'd10, 32'hD000_6000, 8'd1, 3'b010, 2'b01);
        wSend(32'h700, 4'hF, 1'b0);
        wSend(32'h701, 4'hF, 1'b0);
        bTake(4'd10, 2'b10, 0);
        checkBurst("no_wlast", 2, 32'hD000_6000, 1'b0, 32'h700);

        // AW and first W presented together
        clearPulses();
        @(negedge clk);
        AWID = 4'd11; AWADDR = 32'hD000_7000; AWLEN = 8'd0; AWSIZE = 3'b010; AWBURST = 2'b01;
        AWVALID = 1'b1;
        WDATA = 32'h800; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
        checkOutput("same_cycle_awready", AWREADY, 1);
        checkOutput("same_cycle_wready", WREADY, 0);
        @(posedge clk);
        awCycle = cycle;
        #1 AWVALID = 1'b0;
        @(negedge clk);
        checkOutput("same_cycle_wready_next", WREADY, 1);
        @(posedge clk);
        wCycle = cycle;
        #1 WVALID = 1'b0; WLAST = 1'b0;
        checkOutput("same_cycle_w_accept", wCycle, awCycle + 1);
        bTake(4'd11, 2'b00, 0);
        checkBurst("same_cycle", 1, 32'hD000_7000, 1'b0, 32'h800);
        if (obsCycle.size() == 1) checkOutput("same_cycle_pulse", obsCycle[0], awCycle + 2);

        // reset on beat 100 of a 216-beat burst
        clearPulses();
        awSend(4'd12, 32'hD333_0000, 8'd215, 3'b010, 2'b01);
        for (int i = 0; i < 100; i++) wSend(32'(i), 4'hF, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("midrst_ctrl_awvalid", ctrl_awvalid, 0);
        checkOutput("midrst_ctrl_wvalid", ctrl_wvalid, 0);
        checkOutput("midrst_ctrl_awaddr", ctrl_awaddr, 0);
        checkOutput("midrst_ctrl_wdata", ctrl_wdata, 0);
        checkOutput("midrst_wready", WREADY, 0);
        checkOutput("midrst_awready", AWREADY, 0);
        checkOutput("midrst_bid", BID, 0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("midrst_bvalid", BVALID, 0);
        end
        checkOutput("midrst_pulses", obsAddr.size(), 99);
        rst = 1'b1;
        clearPulses();
        awSend(4'd13, 32'hD222_0010, 8'd0, 3'b010, 2'b01);
        wSend(32'hCAFE, 4'hF, 1'b1);
        bTake(4'd13, 2'b00, 0);
        checkBurst("post_rst", 1, 32'hD222_0010, 1'b0, 32'hCAFE);
    endtask

    initial begin
        rst = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'b010; AWBURST = 2'b01; AWVALID = 1'b0;
        WDATA = '0; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_awready", AWREADY, 0);
        checkOutput("rst_wready", WREADY, 0);
        checkOutput("rst_bvalid", BVALID, 0);
        checkOutput("rst_bresp", BRESP, 0);
        checkOutput("rst_bid", BID, 0);
        checkOutput("rst_ctrl_awaddr", ctrl_awaddr, 0);
        checkOutput("rst_ctrl_wdata", ctrl_wdata, 0);
        checkOutput("rst_ctrl_valid", {ctrl_awvalid, ctrl_wvalid}, 0);
        rst = 1'b1;
        #1 checkOutput("rst_release_awready", AWREADY, 0);
        @(negedge clk);
        checkOutput("first_cycle_awready", AWREADY, 1);
        applyStimulus();
        checkOutput("valid_pairing", pairErr, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
